// File: rtl/alu_operand_pkg.sv
// Shared constants and encodings for the ALU operand stage.
package alu_operand_pkg;

    localparam int unsigned DEF_REG_AW = 5;
    localparam logic [DEF_REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Single-operand forward resolution: EX beats WB beats register data; r0 never forwards.
module operand_fwd_mux
    import alu_operand_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data_c
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_REG;
        if (addr != REG_AW'(ZERO_REG)) begin
            if (ex_valid && (addr == ex_addr)) begin
                sel = FWD_EX;
            end else if (wb_valid && (addr == wb_addr)) begin
                sel = FWD_WB;
            end
        end
    end

    always_comb begin
        data_c = reg_data;
        case (sel)
            FWD_EX:  data_c = ex_data;
            FWD_WB:  data_c = wb_data;
            default: data_c = reg_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Resolves ALU operands (forwarding, immediate extension) and holds them in a
// 2-entry skid buffer so the ALU can stall without dropping decoded beats.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_imm_signed,
    input  logic              in_alu_src,
    input  logic              fwd_ex_valid,
    input  logic [REG_AW-1:0] fwd_ex_addr,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic              fwd_wb_valid,
    input  logic [REG_AW-1:0] fwd_wb_addr,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_st_data
);

    state_t state, state_nxt;

    logic [DATA_W-1:0] rs_res_c, rt_res_c;
    logic [DATA_W-1:0] imm_sx_c, imm_zx_c, imm_ext_c;
    logic [DATA_W-1:0] new_b_c;
    logic signed [IMM_W-1:0] imm_s_c;

    logic [DATA_W-1:0] skid_a, skid_b, skid_st;

    logic accept_c, pop_c;
    logic head_ld_in_c, head_ld_skid_c, skid_ld_c;

    operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .addr     (in_rs_addr),
        .reg_data (in_rs_data),
        .ex_valid (fwd_ex_valid),
        .ex_addr  (fwd_ex_addr),
        .ex_data  (fwd_ex_data),
        .wb_valid (fwd_wb_valid),
        .wb_addr  (fwd_wb_addr),
        .wb_data  (fwd_wb_data),
        .data_c   (rs_res_c)
    );

    operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .addr     (in_rt_addr),
        .reg_data (in_rt_data),
        .ex_valid (fwd_ex_valid),
        .ex_addr  (fwd_ex_addr),
        .ex_data  (fwd_ex_data),
        .wb_valid (fwd_wb_valid),
        .wb_addr  (fwd_wb_addr),
        .wb_data  (fwd_wb_data),
        .data_c   (rt_res_c)
    );

    // Casting a signed operand to the wider width sign-extends it.
    assign imm_s_c   = in_imm;
    assign imm_sx_c  = DATA_W'(imm_s_c);
    assign imm_zx_c  = DATA_W'(in_imm);
    assign imm_ext_c = in_imm_signed ? imm_sx_c : imm_zx_c;
    assign new_b_c   = in_alu_src ? rt_res_c : imm_ext_c;

    assign accept_c = in_valid && in_ready;
    assign pop_c    = out_valid && out_ready;

    // Next-state and register-load selection; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        head_ld_in_c   = 1'b0;
        head_ld_skid_c = 1'b0;
        skid_ld_c      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept_c) begin
                        state_nxt    = ONE;
                        head_ld_in_c = 1'b1;
                    end
                end
                ONE: begin
                    if (accept_c && pop_c) begin
                        head_ld_in_c = 1'b1;
                    end else if (accept_c) begin
                        state_nxt = TWO;
                        skid_ld_c = 1'b1;
                    end else if (pop_c) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop_c) begin
                        state_nxt      = ONE;
                        head_ld_skid_c = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready/out_valid are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != TWO);
            out_valid <= (state_nxt != EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a       <= '0;
            out_b       <= '0;
            out_st_data <= '0;
            skid_a      <= '0;
            skid_b      <= '0;
            skid_st     <= '0;
        end else begin
            if (head_ld_in_c) begin
                out_a       <= rs_res_c;
                out_b       <= new_b_c;
                out_st_data <= rt_res_c;
            end else if (head_ld_skid_c) begin
                out_a       <= skid_a;
                out_b       <= skid_b;
                out_st_data <= skid_st;
            end
            if (skid_ld_c) begin
                skid_a  <= rs_res_c;
                skid_b  <= new_b_c;
                skid_st <= rt_res_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs_addr, in_rt_addr;
    logic [31:0] in_rs_data, in_rt_data;
    logic [15:0] in_imm;
    logic        in_imm_signed, in_alu_src;
    logic        fwd_ex_valid, fwd_wb_valid;
    logic [4:0]  fwd_ex_addr, fwd_wb_addr;
    logic [31:0] fwd_ex_data, fwd_wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_st_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs_addr   (in_rs_addr),
        .in_rt_addr   (in_rt_addr),
        .in_rs_data   (in_rs_data),
        .in_rt_data   (in_rt_data),
        .in_imm       (in_imm),
        .in_imm_signed(in_imm_signed),
        .in_alu_src   (in_alu_src),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_addr  (fwd_ex_addr),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_addr  (fwd_wb_addr),
        .fwd_wb_data  (fwd_wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_st_data  (out_st_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd,
                        input logic [15:0] imm, input logic sgn, input logic src);
        in_valid      = 1'b1;
        in_rs_addr    = rs;
        in_rs_data    = rsd;
        in_rt_addr    = rt;
        in_rt_data    = rtd;
        in_imm        = imm;
        in_imm_signed = sgn;
        in_alu_src    = src;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_rs_addr = '0; in_rt_addr = '0; in_rs_data = '0; in_rt_data = '0;
        in_imm = '0; in_imm_signed = 1'b0; in_alu_src = 1'b1;
        fwd_ex_valid = 1'b0; fwd_ex_addr = '0; fwd_ex_data = '0;
        fwd_wb_valid = 1'b0; fwd_wb_addr = '0; fwd_wb_data = '0;
        flush = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_a", out_a, 32'h0);
        check("rst_out_b", out_b, 32'h0);
        check("rst_out_st", out_st_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single beat, register operands.
        beat(5'd3, 32'h11, 5'd4, 32'h22, 16'h0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_a", out_a, 32'h11);
        check("single_b", out_b, 32'h22);
        check("single_st", out_st_data, 32'h22);

        // Immediate extension, back-to-back beats.
        beat(5'd1, 32'h5, 5'd2, 32'h33, 16'h8001, 1'b1, 1'b0);
        tick();
        check("imm_sx_b", out_b, 32'hFFFF8001);
        check("imm_sx_st", out_st_data, 32'h33);
        beat(5'd1, 32'h5, 5'd2, 32'h44, 16'h8001, 1'b0, 1'b0);
        tick();
        check("imm_zx_b", out_b, 32'h00008001);
        check("imm_zx_st", out_st_data, 32'h44);

        // Forwarding priority.
        fwd_ex_valid = 1'b1; fwd_ex_addr = 5'd5; fwd_ex_data = 32'hAAAA;
        fwd_wb_valid = 1'b1; fwd_wb_addr = 5'd5; fwd_wb_data = 32'hBBBB;
        beat(5'd5, 32'h1234, 5'd6, 32'h66, 16'h0, 1'b0, 1'b1);
        tick();
        check("fwd_ex_a", out_a, 32'hAAAA);
        check("fwd_noaddr_b", out_b, 32'h66);
        fwd_ex_valid = 1'b0;
        beat(5'd5, 32'h1234, 5'd6, 32'h66, 16'h0, 1'b0, 1'b1);
        tick();
        check("fwd_wb_a", out_a, 32'hBBBB);
        fwd_ex_valid = 1'b1;
        beat(5'd7, 32'h77, 5'd5, 32'h55, 16'h0, 1'b0, 1'b1);
        tick();
        check("fwd_ex_rt_b", out_b, 32'hAAAA);
        check("fwd_ex_rt_st", out_st_data, 32'hAAAA);
        fwd_ex_addr = 5'd0; fwd_wb_addr = 5'd0;
        beat(5'd0, 32'h77, 5'd0, 32'h88, 16'h0, 1'b0, 1'b1);
        tick();
        check("fwd_r0_a", out_a, 32'h77);
        check("fwd_r0_st", out_st_data, 32'h88);
        fwd_ex_valid = 1'b0; fwd_wb_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: X, Y fill the buffer; Z waits.
        out_ready = 1'b0;
        beat(5'd1, 32'h100, 5'd2, 32'h100, 16'h0, 1'b0, 1'b1);
        tick();
        check("bp_x_a", out_a, 32'h100);
        check("bp_x_ready", 32'(in_ready), 32'd1);
        beat(5'd1, 32'h200, 5'd2, 32'h200, 16'h0, 1'b0, 1'b1);
        tick();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_hold_a", out_a, 32'h100);
        beat(5'd1, 32'h300, 5'd2, 32'h300, 16'h0, 1'b0, 1'b1);
        tick();
        check("bp_z_blocked", 32'(in_ready), 32'd0);
        check("bp_hold_a2", out_a, 32'h100);
        out_ready = 1'b1;
        tick();
        check("bp_y_a", out_a, 32'h200);
        check("bp_y_valid", 32'(out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_z_a", out_a, 32'h300);
        check("bp_z_b", out_b, 32'h300);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: accept and pop every cycle.
        for (int i = 0; i < 8; i++) begin
            beat(5'd1, 32'h1000 + 32'(i), 5'd2, 32'h2000 + 32'(i), 16'h0, 1'b0, 1'b1);
            tick();
            check("stream_a", out_a, 32'h1000 + 32'(i));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_empty", 32'(out_valid), 32'd0);

        // Flush while full with a beat presented.
        out_ready = 1'b0;
        beat(5'd1, 32'hA1, 5'd2, 32'hA1, 16'h0, 1'b0, 1'b1);
        tick();
        beat(5'd1, 32'hA2, 5'd2, 32'hA2, 16'h0, 1'b0, 1'b1);
        tick();
        check("flush_pre_full", 32'(in_ready), 32'd0);
        beat(5'd1, 32'hA3, 5'd2, 32'hA3, 16'h0, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        check("flush_stays_empty", 32'(out_valid), 32'd0);
        tick();
        check("flush_stays_empty2", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        beat(5'd1, 32'hD1, 5'd2, 32'hD1, 16'h0, 1'b0, 1'b1);
        tick();
        beat(5'd1, 32'hD2, 5'd2, 32'hD2, 16'h0, 1'b0, 1'b1);
        tick();
        check("rst_mid_pre", out_a, 32'hD1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_a", out_a, 32'h0);
        check("rst_mid_st", out_st_data, 32'h0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("rst_post_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
